// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ITER,
    S_SIGN,
    S_DONE,
    S_DZERO
  } div_state_e;
endpackage

// File: rtl/div_negate.sv
// Conditional two's-complement: y = en ? -x : x.
module div_negate #(
  parameter int W = 32
) (
  input  logic         en,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);
  assign y = en ? (W'(0) - x) : x;
endmodule

// File: rtl/div_seq.sv
// Sequential signed restoring divider: quotient on lo, remainder on hi.
// Optional DIV_EARLY_OUT_EN skips iteration when |a| < |b|.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] divs_q, divs_d;
  logic             sq_q, sq_d, sr_q, sr_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic [WIDTH-1:0] abs_a, abs_b, lo_fix, hi_fix;
  logic [WIDTH:0]   shifted, diff;

  div_negate #(.W(WIDTH)) u_abs_a  (.en(a[WIDTH-1]), .x(a),     .y(abs_a));
  div_negate #(.W(WIDTH)) u_abs_b  (.en(b[WIDTH-1]), .x(b),     .y(abs_b));
  div_negate #(.W(WIDTH)) u_fix_lo (.en(sq_q),       .x(dvd_q), .y(lo_fix));
  div_negate #(.W(WIDTH)) u_fix_hi (.en(sr_q),       .x(rem_q), .y(hi_fix));

  // Partial remainder stays below |b|, so a clear bit WIDTH means no borrow.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, divs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    divs_d  = divs_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (b == '0) begin
            state_d = S_DZERO;
          end else begin
            divs_d = abs_b;
            sq_d   = a[WIDTH-1] ^ b[WIDTH-1];
            sr_d   = a[WIDTH-1];
            cnt_d  = '0;
`ifdef DIV_EARLY_OUT_EN
            if (abs_a < abs_b) begin
              rem_d   = abs_a;
              dvd_d   = '0;
              state_d = S_SIGN;
            end else
`endif
            begin
              rem_d   = '0;
              dvd_d   = abs_a;
              state_d = S_ITER;
            end
          end
        end
      end
      S_ITER: begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIV_ITERS - 1)) state_d = S_SIGN;
      end
      S_SIGN: begin
        lo_d    = lo_fix;
        hi_d    = hi_fix;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_DZERO: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      divs_q  <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      divs_q  <= divs_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE) || (state_q == S_DZERO);
  assign div_zero = (state_q == S_DZERO);
  assign hi       = hi_q;
  assign lo       = lo_q;
endmodule

// File: tb/tb_div_seq.sv
// Randomized scoreboard bench for div_seq against a plain signed-arithmetic model.
module tb_div_seq;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  div_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          start_edge;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          nvec = 0, nerr = 0, cyc = 0;
  logic [31:0] last_hi = 0, last_lo = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mag(input logic [31:0] x);
    return x[31] ? (32'd0 - x) : x;
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", {31'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("lo", lo, e.lo);
        chk("hi", hi, e.hi);
        chk("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
        chk("latency", cyc - e.start_edge, e.lat);
        chk("busy_at_done", {31'd0, busy}, 32'd1);
      end
    end
  end

  task automatic issue(input logic [31:0] av, input logic [31:0] bv);
    exp_t e;
    int   sa, sbv;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    e.start_edge = cyc + 1;
    if (bv == 0) begin
      e.hi = last_hi; e.lo = last_lo; e.dz = 1'b1; e.lat = 0;
    end else begin
      sa = av; sbv = bv;
      if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
        e.lo = 32'h8000_0000; e.hi = 32'd0;
      end else begin
        e.lo = sa / sbv;
        e.hi = sa % sbv;
      end
      e.dz = 1'b0;
`ifdef DIV_EARLY_OUT_EN
      e.lat = (mag(av) < mag(bv)) ? 1 : 33;
`else
      e.lat = 33;
`endif
      last_hi = e.hi; last_lo = e.lo;
    end
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom;   // operands may change once captured
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
    chk("busy_after", {31'd0, busy}, 32'd0);
  endtask

  task automatic run(input logic [31:0] av, input logic [31:0] bv);
    issue(av, bv);
    wait_idle();
  endtask

  initial begin
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; a = 0; b = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dz", {31'd0, div_zero}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;

    run(32'd7, 32'd2);
    run(32'hFFFF_FFF9, 32'd2);
    run(32'd7, 32'hFFFF_FFFE);
    run(32'd7, 32'd2);
    run(32'd5, 32'd0);
    chk("dz_hold_hi", hi, 32'd1);
    chk("dz_hold_lo", lo, 32'd3);
    run(32'h8000_0000, 32'hFFFF_FFFF);
    run(32'd3, 32'd10);
    run(32'h8000_0000, 32'h8000_0000);
    run(32'h7FFF_FFFF, 32'h8000_0000);
    run(32'd0, 32'd9);

    // Second start while busy is dropped.
    issue(32'd100, 32'd7);
    repeat (9) @(negedge clk);
    a = 32'd1; b = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Back-to-back: issue right after done.
    issue(32'd1000, 32'd33);
    while (sb.size() != 0 && cyc < 90000) @(negedge clk);
    run(32'hFFFF_FC18, 32'd33);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 20);
        2: rb = 32'd0 - $urandom_range(1, 20);
        3: begin rb = $urandom; ra = ra >> $urandom_range(0, 31); end
        default: rb = $urandom;
      endcase
      run(ra, rb);
    end

    // Reset mid-operation: no result, everything cleared.
    @(negedge clk);
    a = 32'd1000; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_hi = 0; last_lo = 0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    repeat (40) @(negedge clk);
    run(32'hFFFF_FFF9, 32'hFFFF_FFFE);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
